tmr_vote_monitor: RTL and testbench
===================================

Name: tmr_vote_monitor

Overview:
- Registered triple-modular-redundancy voter with per-lane health tracking.
- Consumes three replicated data words A, B, C and produces the voted word Y, one cycle later.
- Watches each lane against the vote. A lane that disagrees persistently is declared failed and masked from later votes.
- Sits between the replicated producers and every downstream consumer of the voted signal; fault flags go to the system status logic.

Parameters:
- W, 8, data width of each lane and of Y.
- FAIL_THRESH, 4, consecutive mismatching samples that move a lane SUSPECT→FAILED (legal range 2..15).
- RECOVER_THRESH, 3, consecutive matching samples that move a lane SUSPECT→HEALTHY (legal range 1..15).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  A/B/C hold a sample this cycle.
- A  in  W  lane 0 data.
- B  in  W  lane 1 data.
- C  in  W  lane 2 data.
- clear_fault  in  3  one-cycle pulse per lane (bit0=A, bit1=B, bit2=C); forces that lane to HEALTHY.
- out_valid  out  1  Y updated from the sample of the previous cycle.
- Y  out  W  voted word.
- lane_fail  out  3  lane in FAILED state; bit order matches clear_fault.
- lane_suspect  out  3  lane in SUSPECT state.
- no_consensus  out  1  no valid vote for the last sample; Y held.
- sys_fail  out  1  two or more lanes in FAILED state.

Behaviour:
- Reset: Y=0, out_valid=0, lane_fail=0, lane_suspect=0, no_consensus=0, sys_fail=0. All lanes HEALTHY; all counters 0.
- Latency: sample with in_valid=1 at edge n gives Y and out_valid=1 at edge n+1. out_valid=0 in any cycle after in_valid=0. Y holds its value when in_valid=0.
- Vote, by number of non-FAILED lanes:
  - 3 active: bitwise majority (X&Y)|(X&Z)|(Y&Z) per bit.
  - 2 active and equal: Y = that word.
  - 2 active and unequal: Y holds, no_consensus=1.
  - Fewer than 2 active: Y holds, no_consensus=1, sys_fail=1.
- no_consensus is updated only on valid samples and is otherwise held.
- Mismatch: an active lane mismatches when its word ≠ Y_next (any bit differs). With no consensus, no lane is evaluated and all health counters hold.
- FAILED lanes are not evaluated; they never self-recover.
- Per-lane FSM, advanced only on valid samples:
  - HEALTHY: mismatch → SUSPECT, miss_cnt=1, hit_cnt=0.
  - SUSPECT, mismatch: miss_cnt+1 and hit_cnt=0. When miss_cnt reaches FAIL_THRESH → FAILED.
  - SUSPECT, match: hit_cnt+1 and miss_cnt=0. When hit_cnt reaches RECOVER_THRESH → HEALTHY.
  - FAILED: stays until clear_fault bit=1, then → HEALTHY with counters 0.
- clear_fault priority: takes priority over a same-cycle evaluation of that lane. The cleared lane is excluded from that cycle's vote (treated as FAILED for that edge) and is active from the next sample.
- Status outputs are registered and change on the same edge as Y.
- Reset asserted mid-operation clears everything immediately, with no partial update. The first valid sample after reset deassertion votes with all 3 lanes.

Decomposition:
- Shared package tmr_pkg:
  - lane state enum: HEALTHY=2'b00, SUSPECT=2'b01, FAILED=2'b10.
  - CNT_W=4.
  - Lane index constants LANE_A=0, LANE_B=1, LANE_C=2.
- Sub-module lane_health_fsm, instantiated three times.
  - Inputs: clk, reset, eval, mismatch, clear.
  - Outputs: state, is_failed, is_suspect.
  - Holds miss_cnt/hit_cnt, parameterised by FAIL_THRESH and RECOVER_THRESH.
- Top level holds the vote mux, output registers, and sys_fail/no_consensus logic.

Test Plan:
- Reset, then A=B=C=8'h5A with in_valid=1 → next cycle Y=8'h5A, out_valid=1, all flags 0.
- A=8'h00, B=C=8'hFF for 4 valid cycles → lane_suspect[0]=1 after cycle 1; lane_fail[0]=1 and lane_suspect[0]=0 after cycle 4; Y=8'hFF throughout.
- A wrong for 2 samples, then correct for 3 → lane_suspect[0] clears after the 3rd match; lane_fail stays 0.
- Lane A failed, then B=8'h11, C=8'h22 → Y holds its previous value and no_consensus=1. Next sample B=C=8'h33 → Y=8'h33 and no_consensus=0.
- Lanes A and B failed → sys_fail=1. Pulse clear_fault=3'b001 while A=C → lane_fail=3'b010 on the same edge; sys_fail=0 from the next sample.
- Assert reset for 1 cycle mid-run with lane_fail=3'b100 and Y=8'hAA → immediately Y=0, lane_fail=0, out_valid=0.

Source files
------------

// File: rtl/tmr_pkg.sv
// Shared types and constants for the TMR voter and its lane health trackers.
// Pure declarations, no timing.
// No flow control.
package tmr_pkg;

  typedef enum logic [1:0] {
    HEALTHY = 2'b00,
    SUSPECT = 2'b01,
    FAILED  = 2'b10
  } lane_state_t;

  localparam int CNT_W     = 4;
  localparam int LANE_A    = 0;
  localparam int LANE_B    = 1;
  localparam int LANE_C    = 2;
  localparam int NUM_LANES = 3;

  // Population count of a 3-bit lane mask.
  function automatic logic [1:0] count3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/lane_health_fsm.sv
// Per-lane health tracker: HEALTHY -> SUSPECT -> FAILED on persistent mismatch.
// State and counters update on the clock edge after eval; outputs come straight from flops.
// No backpressure; clear always wins over a same-cycle evaluation.
module lane_health_fsm
  import tmr_pkg::*;
#(
  parameter int FAIL_THRESH    = 4,
  parameter int RECOVER_THRESH = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        eval,
  input  logic        mismatch,
  input  logic        clear,
  output lane_state_t state,
  output logic        is_failed,
  output logic        is_suspect
);

  localparam logic [CNT_W-1:0] FAIL_LIM = CNT_W'(FAIL_THRESH);
  localparam logic [CNT_W-1:0] REC_LIM  = CNT_W'(RECOVER_THRESH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  lane_state_t      state_q, state_next;
  logic [CNT_W-1:0] miss_q, miss_next;
  logic [CNT_W-1:0] hit_q, hit_next;
  logic [CNT_W-1:0] miss_inc, hit_inc;

  assign miss_inc = miss_q + CNT_ONE;
  assign hit_inc  = hit_q + CNT_ONE;

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HEALTHY;
      miss_q  <= '0;
      hit_q   <= '0;
    end else begin
      state_q <= state_next;
      miss_q  <= miss_next;
      hit_q   <= hit_next;
    end
  end

  // Next-state: clear first, then evaluation of the current sample.
  always_comb begin
    state_next = state_q;
    miss_next  = miss_q;
    hit_next   = hit_q;
    if (clear) begin
      state_next = HEALTHY;
      miss_next  = '0;
      hit_next   = '0;
    end else if (eval) begin
      case (state_q)
        HEALTHY: begin
          if (mismatch) begin
            state_next = SUSPECT;
            miss_next  = CNT_ONE;
            hit_next   = '0;
          end
        end
        SUSPECT: begin
          if (mismatch) begin
            hit_next = '0;
            if (miss_inc == FAIL_LIM) begin
              state_next = FAILED;
              miss_next  = '0;
            end else begin
              miss_next = miss_inc;
            end
          end else begin
            miss_next = '0;
            if (hit_inc == REC_LIM) begin
              state_next = HEALTHY;
              hit_next   = '0;
            end else begin
              hit_next = hit_inc;
            end
          end
        end
        default: ;  // FAILED lanes only leave via clear
      endcase
    end
  end

  // Status decode from the registered state.
  always_comb begin
    state      = state_q;
    is_failed  = (state_q == FAILED);
    is_suspect = (state_q == SUSPECT);
  end

endmodule

// File: rtl/tmr_vote_monitor.sv
// Registered TMR voter with per-lane health tracking and fault masking.
// One cycle from a valid sample to Y/out_valid; status flags change on the same edge.
// No backpressure; samples are taken whenever in_valid is high.
module tmr_vote_monitor
  import tmr_pkg::*;
#(
  parameter int W              = 8,
  parameter int FAIL_THRESH    = 4,
  parameter int RECOVER_THRESH = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [W-1:0] C,
  input  logic [2:0]   clear_fault,
  output logic         out_valid,
  output logic [W-1:0] Y,
  output logic [2:0]   lane_fail,
  output logic [2:0]   lane_suspect,
  output logic         no_consensus,
  output logic         sys_fail
);

  logic [W-1:0] lane_dat [NUM_LANES];
  lane_state_t  lane_state [NUM_LANES];
  logic [2:0]   active;
  logic [2:0]   eval;
  logic [2:0]   mismatch;
  logic [1:0]   active_cnt;
  logic [1:0]   fail_cnt;
  logic [W-1:0] y_q, y_next;
  logic         consensus;
  logic         starved_q;

  assign lane_dat[LANE_A] = A;
  assign lane_dat[LANE_B] = B;
  assign lane_dat[LANE_C] = C;

  // A lane being cleared sits out this edge's vote and rejoins on the next sample.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign active[i]   = (lane_state[i] != FAILED) & ~clear_fault[i];
    assign mismatch[i] = (lane_dat[i] != y_next);
    assign eval[i]     = in_valid & consensus & active[i];

    lane_health_fsm #(
      .FAIL_THRESH   (FAIL_THRESH),
      .RECOVER_THRESH(RECOVER_THRESH)
    ) u_fsm (
      .clk       (clk),
      .reset     (reset),
      .eval      (eval[i]),
      .mismatch  (mismatch[i]),
      .clear     (clear_fault[i]),
      .state     (lane_state[i]),
      .is_failed (lane_fail[i]),
      .is_suspect(lane_suspect[i])
    );
  end

  assign active_cnt = count3(active);
  assign fail_cnt   = count3(lane_fail);

  // Vote mux: majority with three lanes, agreement check with two, else hold.
  always_comb begin
    y_next    = y_q;
    consensus = 1'b0;
    case (active)
      3'b111: begin
        y_next    = (A & B) | (A & C) | (B & C);
        consensus = 1'b1;
      end
      3'b011: if (A == B) begin y_next = A; consensus = 1'b1; end
      3'b101: if (A == C) begin y_next = A; consensus = 1'b1; end
      3'b110: if (B == C) begin y_next = B; consensus = 1'b1; end
      default: ;
    endcase
  end

  // Output and vote-status registers; only valid samples move Y and the vote flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_q          <= '0;
      out_valid    <= 1'b0;
      no_consensus <= 1'b0;
      starved_q    <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y_q          <= y_next;
        no_consensus <= ~consensus;
        starved_q    <= (active_cnt < 2'd2);
      end
    end
  end

  assign Y        = y_q;
  assign sys_fail = (fail_cnt >= 2'd2) | starved_q;

endmodule

// File: tb/tb_tmr_vote_monitor.sv
// Bench for tmr_vote_monitor: directed vector table, reset corner case, random vs model.
// Checks sampled 1ns after each rising edge.
// No backpressure involved.
module tb_tmr_vote_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] A = '0, B = '0, C = '0;
  logic [2:0] clear_fault = '0;
  logic       out_valid;
  logic [7:0] Y;
  logic [2:0] lane_fail, lane_suspect;
  logic       no_consensus, sys_fail;

  int checks = 0;
  int failures = 0;

  tmr_vote_monitor #(.W(8), .FAIL_THRESH(4), .RECOVER_THRESH(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .A(A), .B(B), .C(C),
    .clear_fault(clear_fault), .out_valid(out_valid), .Y(Y),
    .lane_fail(lane_fail), .lane_suspect(lane_suspect),
    .no_consensus(no_consensus), .sys_fail(sys_fail)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] ey, input logic eov,
                           input logic [2:0] ef, input logic [2:0] es,
                           input logic enc, input logic esf);
    check({tag, ".Y"}, Y, ey);
    check({tag, ".out_valid"}, 8'(out_valid), 8'(eov));
    check({tag, ".lane_fail"}, 8'(lane_fail), 8'(ef));
    check({tag, ".lane_suspect"}, 8'(lane_suspect), 8'(es));
    check({tag, ".no_consensus"}, 8'(no_consensus), 8'(enc));
    check({tag, ".sys_fail"}, 8'(sys_fail), 8'(esf));
  endtask

  // Directed vectors: inputs for one cycle and the outputs expected after that edge.
  typedef struct {
    logic       v;
    logic [7:0] a, b, c;
    logic [2:0] clr;
    logic [7:0] y;
    logic       ov;
    logic [2:0] f, s;
    logic       nc, sf;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic v, logic [7:0] a, logic [7:0] b, logic [7:0] c,
                              logic [2:0] clr, logic [7:0] y, logic ov, logic [2:0] f,
                              logic [2:0] s, logic nc, logic sf);
    vec_t t;
    t.v = v; t.a = a; t.b = b; t.c = c; t.clr = clr;
    t.y = y; t.ov = ov; t.f = f; t.s = s; t.nc = nc; t.sf = sf;
    tbl.push_back(t);
  endfunction

  // Reference model, in terms of lane health states and thresholds.
  localparam int M_HEALTHY = 0, M_SUSPECT = 1, M_FAILED = 2;
  int         m_st[3], m_miss[3], m_hit[3];
  logic [7:0] m_y;
  logic       m_ov, m_nc, m_starve;

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin m_st[i] = M_HEALTHY; m_miss[i] = 0; m_hit[i] = 0; end
    m_y = '0; m_ov = 0; m_nc = 0; m_starve = 0;
  endfunction

  function automatic void model_step(logic v, logic [7:0] a, logic [7:0] b, logic [7:0] c,
                                     logic [2:0] clr);
    logic [7:0] w[3];
    bit         act[3];
    int         n, ones, first, second;
    bit         cons;
    logic [7:0] vote;
    w[0] = a; w[1] = b; w[2] = c;
    n = 0; first = -1; second = -1;
    for (int i = 0; i < 3; i++) begin
      act[i] = (m_st[i] != M_FAILED) && !clr[i];
      if (act[i]) begin
        n++;
        if (first < 0) first = i; else second = i;
      end
    end
    cons = 0; vote = m_y;
    if (n == 3) begin
      for (int k = 0; k < 8; k++) begin
        ones = int'(a[k]) + int'(b[k]) + int'(c[k]);
        vote[k] = (ones >= 2);
      end
      cons = 1;
    end else if (n == 2 && w[first] == w[second]) begin
      vote = w[first];
      cons = 1;
    end
    m_ov = v;
    if (v) begin
      if (cons) m_y = vote;
      m_nc = !cons;
      m_starve = (n < 2);
    end
    for (int i = 0; i < 3; i++) begin
      if (clr[i]) begin
        m_st[i] = M_HEALTHY; m_miss[i] = 0; m_hit[i] = 0;
      end else if (v && cons && act[i]) begin
        if (w[i] != vote) begin
          m_hit[i] = 0;
          m_miss[i] = (m_st[i] == M_HEALTHY) ? 1 : m_miss[i] + 1;
          m_st[i] = (m_miss[i] >= 4) ? M_FAILED : M_SUSPECT;
          if (m_st[i] == M_FAILED) m_miss[i] = 0;
        end else if (m_st[i] == M_SUSPECT) begin
          m_miss[i] = 0;
          m_hit[i]++;
          if (m_hit[i] >= 3) begin m_st[i] = M_HEALTHY; m_hit[i] = 0; end
        end
      end
    end
  endfunction

  function automatic logic [2:0] m_fail_vec();
    logic [2:0] r;
    for (int i = 0; i < 3; i++) r[i] = (m_st[i] == M_FAILED);
    return r;
  endfunction

  function automatic logic [2:0] m_susp_vec();
    logic [2:0] r;
    for (int i = 0; i < 3; i++) r[i] = (m_st[i] == M_SUSPECT);
    return r;
  endfunction

  function automatic logic m_sys_fail();
    int nf;
    nf = 0;
    for (int i = 0; i < 3; i++) if (m_st[i] == M_FAILED) nf++;
    return (nf >= 2) || m_starve;
  endfunction

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [2:0] clr);
    in_valid = v; A = a; B = b; C = c; clear_fault = clr;
    @(posedge clk);
    #1;
    clear_fault = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0; clear_fault = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  logic [7:0] ra, rb, rc, base;
  logic [2:0] rclr;
  logic       rv;

  initial begin
    // Directed sequence: recovery, failure, no-consensus, double failure, clear.
    add(1, 8'h5A, 8'h5A, 8'h5A, 3'b000, 8'h5A, 1, 3'b000, 3'b000, 0, 0);
    add(1, 8'h00, 8'hFF, 8'hFF, 3'b000, 8'hFF, 1, 3'b000, 3'b001, 0, 0);
    add(1, 8'h00, 8'hFF, 8'hFF, 3'b000, 8'hFF, 1, 3'b000, 3'b001, 0, 0);
    add(1, 8'hFF, 8'hFF, 8'hFF, 3'b000, 8'hFF, 1, 3'b000, 3'b001, 0, 0);
    add(1, 8'hFF, 8'hFF, 8'hFF, 3'b000, 8'hFF, 1, 3'b000, 3'b001, 0, 0);
    add(1, 8'hFF, 8'hFF, 8'hFF, 3'b000, 8'hFF, 1, 3'b000, 3'b000, 0, 0);
    for (int i = 0; i < 3; i++)
      add(1, 8'h00, 8'hFF, 8'hFF, 3'b000, 8'hFF, 1, 3'b000, 3'b001, 0, 0);
    add(1, 8'h00, 8'hFF, 8'hFF, 3'b000, 8'hFF, 1, 3'b001, 3'b000, 0, 0);
    add(1, 8'h00, 8'h11, 8'h22, 3'b000, 8'hFF, 1, 3'b001, 3'b000, 1, 0);
    add(1, 8'h00, 8'h33, 8'h33, 3'b000, 8'h33, 1, 3'b001, 3'b000, 0, 0);
    add(0, 8'h00, 8'h00, 8'h00, 3'b000, 8'h33, 0, 3'b001, 3'b000, 0, 0);
    add(1, 8'h33, 8'h33, 8'h33, 3'b001, 8'h33, 1, 3'b000, 3'b000, 0, 0);
    for (int i = 0; i < 3; i++)
      add(1, 8'h01, 8'h02, 8'h00, 3'b000, 8'h00, 1, 3'b000, 3'b011, 0, 0);
    add(1, 8'h01, 8'h02, 8'h00, 3'b000, 8'h00, 1, 3'b011, 3'b000, 0, 1);
    add(1, 8'h55, 8'h55, 8'h55, 3'b000, 8'h00, 1, 3'b011, 3'b000, 1, 1);
    add(1, 8'h66, 8'h00, 8'h66, 3'b001, 8'h00, 1, 3'b010, 3'b000, 1, 1);
    add(1, 8'h77, 8'h00, 8'h77, 3'b000, 8'h77, 1, 3'b010, 3'b000, 0, 0);
    add(1, 8'hAA, 8'h00, 8'hAA, 3'b010, 8'hAA, 1, 3'b000, 3'b000, 0, 0);
    for (int i = 0; i < 3; i++)
      add(1, 8'hAA, 8'hAA, 8'h00, 3'b000, 8'hAA, 1, 3'b000, 3'b100, 0, 0);
    add(1, 8'hAA, 8'hAA, 8'h00, 3'b000, 8'hAA, 1, 3'b100, 3'b000, 0, 0);

    do_reset();
    check_all("reset", 8'h00, 0, 3'b000, 3'b000, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].clr);
      check_all($sformatf("vec%0d", i), tbl[i].y, tbl[i].ov, tbl[i].f, tbl[i].s,
                tbl[i].nc, tbl[i].sf);
    end

    // Asynchronous reset mid-run, with lane C failed and Y=AA: clears without a clock edge.
    in_valid = 1'b1; A = 8'hAA; B = 8'hAA; C = 8'hAA;
    #1;
    reset = 1'b1;
    #1;
    check_all("async_reset", 8'h00, 0, 3'b000, 3'b000, 0, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    // First sample after reset must vote with all three lanes (C no longer masked).
    drive(1, 8'h01, 8'h03, 8'h03, 3'b000);
    check_all("post_reset_vote", 8'h03, 1, 3'b000, 3'b001, 0, 0);

    // Random phase against the model.
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      rv   = ($urandom_range(0, 7) != 0);
      base = 8'($urandom_range(0, 3));
      ra   = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : base;
      rb   = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 3)) : base;
      rc   = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 3)) : base;
      rclr = '0;
      for (int k = 0; k < 3; k++) rclr[k] = ($urandom_range(0, 15) == 0);
      model_step(rv, ra, rb, rc, rclr);
      drive(rv, ra, rb, rc, rclr);
      check_all($sformatf("rnd%0d", n), m_y, m_ov, m_fail_vec(), m_susp_vec(), m_nc,
                m_sys_fail());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
